// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch unit
//
// Purpose: fetches one instruction word at a time from instruction memory,
// holds it for the downstream core until consumed, and restarts fetch on a
// redirect. At most one memory request is outstanding at any time.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-low reset
//   imem_req     out  1   request valid (only in the request state)
//   imem_addr    out  32  word-aligned fetch address (always fetch_pc)
//   imem_gnt     in   1   request accepted this cycle
//   imem_rvalid  in   1   read data valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   redirect     in   1   restart fetch at redirect_pc
//   redirect_pc  in   32  new fetch target (low two bits ignored)
//   stall        in   1   downstream cannot accept this cycle
//   if_valid     out  1   if_pc/if_instr hold a valid instruction
//   if_pc        out  32  PC of the held instruction
//   if_instr     out  32  held instruction, NOP_INSTR when nothing held
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic        if_valid_n;
   logic [31:0] if_pc_n, if_instr_n;
   logic [31:0] redirect_target;

   assign redirect_target = {redirect_pc[31:2], 2'b00};

   assign imem_req  = (state == S_REQ);
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         if_valid <= 1'b0;
         if_pc    <= 32'h0;
         if_instr <= NOP_INSTR;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         if_valid <= if_valid_n;
         if_pc    <= if_pc_n;
         if_instr <= if_instr_n;
      end
   end

   always_comb begin
      state_n    = state;
      fetch_pc_n = fetch_pc;
      if_valid_n = if_valid;
      if_pc_n    = if_pc;
      if_instr_n = if_instr;
      case (state)
         S_REQ: begin
            if (redirect) begin
               fetch_pc_n = redirect_target;
               // A granted request must still have its response swallowed.
               state_n    = imem_gnt ? S_DROP : S_REQ;
            end else if (imem_gnt) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               fetch_pc_n = redirect_target;
               // Response arriving with the redirect is stale: drop it now.
               state_n    = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               if_valid_n = 1'b1;
               if_pc_n    = fetch_pc;
               if_instr_n = imem_rdata;
               state_n    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               if_valid_n = 1'b0;
               if_instr_n = NOP_INSTR;
               fetch_pc_n = redirect_target;
               state_n    = S_REQ;
            end else if (!stall) begin
               if_valid_n = 1'b0;
               if_instr_n = NOP_INSTR;
               fetch_pc_n = fetch_pc + 32'd4;
               state_n    = S_REQ;
            end
         end
         S_DROP: begin
            // A redirect here only retargets; the outstanding response is
            // still the one to swallow, so rvalid always ends the drop.
            if (redirect) begin
               fetch_pc_n = redirect_target;
            end
            if (imem_rvalid) begin
               state_n = S_REQ;
            end
         end
         default: begin
            state_n = S_REQ;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] WRPC  = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        if_valid;
   logic [31:0] if_pc, if_instr;

   logic        w_reset;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_gnt, w_rvalid;
   logic [31:0] w_rdata;
   logic        w_redirect;
   logic [31:0] w_redirect_pc;
   logic        w_stall;
   logic        w_valid;
   logic [31:0] w_pc, w_instr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
   );

   instr_fetch_unit #(.RESET_PC(WRPC), .NOP_INSTR(NOP)) dut_wrap (
      .clk(clk), .reset(w_reset),
      .imem_req(w_req), .imem_addr(w_addr),
      .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .redirect(w_redirect), .redirect_pc(w_redirect_pc), .stall(w_stall),
      .if_valid(w_valid), .if_pc(w_pc), .if_instr(w_instr)
   );

   // Transaction-level reference: a held instruction, an outstanding
   // memory request, and whether that outstanding response is unwanted.
   logic [31:0] m_pc;
   logic        m_held;
   logic        m_outst;
   logic        m_disc;
   logic [31:0] m_ifpc;
   logic [31:0] m_instr;

   int p_gnt, p_rv, p_stall, p_redir, p_stray;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = RPC;
      m_held  = 1'b0;
      m_outst = 1'b0;
      m_disc  = 1'b0;
      m_ifpc  = 32'h0;
      m_instr = NOP;
   endtask

   task automatic model_step();
      logic        granted;
      logic [31:0] pc_n;
      logic        held_n, outst_n, disc_n;
      granted = !m_held && !m_outst && imem_gnt;
      pc_n    = m_pc;
      held_n  = m_held;
      outst_n = m_outst;
      disc_n  = m_disc;
      if (m_outst && imem_rvalid) begin
         if (!m_disc && !redirect) begin
            held_n  = 1'b1;
            m_ifpc  = m_pc;
            m_instr = imem_rdata;
         end
         outst_n = 1'b0;
         disc_n  = 1'b0;
      end
      if (m_held && (redirect || !stall)) begin
         held_n  = 1'b0;
         m_instr = NOP;
         if (!redirect) pc_n = m_pc + 32'd4;
      end
      if (granted) begin
         outst_n = 1'b1;
         disc_n  = redirect;
      end else if (redirect && outst_n) begin
         disc_n = 1'b1;
      end
      if (redirect) pc_n = redirect_pc & 32'hFFFF_FFFC;
      m_pc    = pc_n;
      m_held  = held_n;
      m_outst = outst_n;
      m_disc  = disc_n;
   endtask

   task automatic compare_all();
      chk("imem_req",  {31'b0, imem_req}, {31'b0, !m_held && !m_outst});
      chk("imem_addr", imem_addr, m_pc);
      chk("if_valid",  {31'b0, if_valid}, {31'b0, m_held});
      chk("if_pc",     if_pc, m_ifpc);
      chk("if_instr",  if_instr, m_instr);
   endtask

   task automatic drive_idle();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
   endtask

   task automatic drive_random();
      imem_gnt    = ($urandom_range(99) < p_gnt);
      imem_rvalid = m_outst ? ($urandom_range(99) < p_rv) : ($urandom_range(99) < p_stray);
      imem_rdata  = $urandom;
      redirect    = ($urandom_range(99) < p_redir);
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(15);
      else                        redirect_pc = $urandom;
      stall       = ($urandom_range(99) < p_stall);
   endtask

   // Entered and left at a falling edge.
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         compare_all();
         drive_random();
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      w_reset = 1'b0;
      drive_idle();
      w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
      w_redirect = 1'b0; w_redirect_pc = 32'h0; w_stall = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();

      // Fetch address wraps when RESET_PC is the last word.
      w_reset = 1'b1;
      chk("wrap_req0",  {31'b0, w_req}, 32'd1);
      chk("wrap_addr0", w_addr, WRPC);
      w_gnt = 1'b1;
      @(negedge clk);
      w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hCAFE_0001;
      @(negedge clk);
      w_rvalid = 1'b0;
      chk("wrap_valid", {31'b0, w_valid}, 32'd1);
      chk("wrap_pc",    w_pc, WRPC);
      chk("wrap_instr", w_instr, 32'hCAFE_0001);
      @(negedge clk);
      chk("wrap_req1",  {31'b0, w_req}, 32'd1);
      chk("wrap_addr1", w_addr, 32'h0000_0000);
      chk("wrap_valid1", {31'b0, w_valid}, 32'd0);

      // Back-to-back fetch with immediate grant/response, no stall.
      reset = 1'b1;
      p_gnt = 100; p_rv = 100; p_stall = 0; p_redir = 0; p_stray = 0;
      run_cycles(12);
      chk("seq_addr", imem_addr, 32'h10);

      // Heavy stall.
      p_gnt = 80; p_rv = 70; p_stall = 75; p_redir = 0; p_stray = 20;
      run_cycles(200);

      // Everything random, including redirects and stray responses.
      p_gnt = 60; p_rv = 50; p_stall = 40; p_redir = 12; p_stray = 10;
      run_cycles(4000);

      // Reset while a wanted response is outstanding, then a stray rvalid.
      p_redir = 0;
      begin
         int guard = 0;
         while (!(m_outst && !m_disc) && guard < 200) begin
            run_cycles(1);
            guard++;
         end
         chk("reach_wait", {31'b0, m_outst && !m_disc}, 32'd1);
      end
      reset = 1'b0;
      drive_idle();
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      compare_all();
      reset = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("post_rst_valid", {31'b0, if_valid}, 32'd0);
      chk("post_rst_addr",  imem_addr, RPC);

      p_gnt = 60; p_rv = 50; p_stall = 40; p_redir = 12; p_stray = 10;
      run_cycles(600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the if_instr value while no instruction is held.
REQ-003 clk  input  1  meaning single clock; all state updates on rising edge.
REQ-004 reset  input  1  meaning asynchronous, active-low reset (0 = reset asserted).
REQ-005 imem_req  output  1  meaning instruction-memory request valid.
REQ-006 imem_addr  output  32  meaning word-aligned fetch address.
REQ-007 imem_gnt  input  1  meaning request accepted this cycle.
REQ-008 imem_rvalid  input  1  meaning read data valid this cycle.
REQ-009 imem_rdata  input  32  meaning fetched instruction word.
REQ-010 redirect  input  1  meaning branch/jump taken; restart fetch at redirect_pc.
REQ-011 redirect_pc  input  32  meaning new fetch target.
REQ-012 stall  input  1  meaning the downstream core cannot accept this cycle.
REQ-013 if_valid  output  1  meaning if_pc/if_instr hold a valid instruction.
REQ-014 if_pc  output  32  meaning PC of the held instruction.
REQ-015 if_instr  output  32  meaning the held instruction.

Function
REQ-016 The FSM SHALL have four states: REQ, WAIT, HOLD and DROP; at most one memory request SHALL be outstanding at any time.
REQ-017 imem_req SHALL be 1 only in REQ, decoded combinationally from state; imem_addr SHALL equal the fetch_pc register in all states.
REQ-018 REQ: on imem_gnt=1 the FSM SHALL go to WAIT; otherwise it SHALL stay in REQ with imem_addr stable.
REQ-019 WAIT: on imem_rvalid=1 the block SHALL register if_instr=imem_rdata, if_pc=fetch_pc and if_valid=1, and SHALL go to HOLD; the response SHALL be visible on the next edge (1-cycle capture latency).
REQ-020 HOLD: while stall=1 the if_* outputs SHALL stay stable; when stall=0 the instruction is consumed, fetch_pc SHALL become fetch_pc+4, if_valid SHALL clear next cycle, and the FSM SHALL go to REQ.
REQ-021 fetch_pc+4 SHALL be computed modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-022 redirect_pc[1:0] SHALL be ignored and forced to 2'b00.
REQ-023 redirect=1 in REQ without imem_gnt: fetch_pc SHALL load redirect_pc and the FSM SHALL stay in REQ.
REQ-024 redirect=1 in REQ with imem_gnt=1: fetch_pc SHALL load redirect_pc and the FSM SHALL go to DROP.
REQ-025 redirect=1 in WAIT without imem_rvalid: fetch_pc SHALL load redirect_pc and the FSM SHALL go to DROP.
REQ-026 redirect=1 in WAIT with imem_rvalid=1: the response SHALL be discarded (if_valid stays 0), fetch_pc SHALL load redirect_pc, and the FSM SHALL go to REQ.
REQ-027 redirect=1 in HOLD: the held instruction SHALL be invalidated (if_valid=0, if_instr=NOP_INSTR next cycle) regardless of stall, fetch_pc SHALL load redirect_pc, and the FSM SHALL go to REQ.
REQ-028 DROP: on imem_rvalid=1 the data SHALL be discarded and the FSM SHALL go to REQ; a further redirect in DROP SHALL only update fetch_pc.
REQ-029 redirect SHALL take priority over stall, imem_gnt and imem_rvalid in every state.
REQ-030 imem_rvalid in REQ or HOLD SHALL be ignored.

Reset
REQ-031 While reset=0 the block SHALL asynchronously set: state=REQ, fetch_pc=RESET_PC, if_valid=0, if_pc=32'h0, if_instr=NOP_INSTR.
REQ-032 In the first cycle after reset releases, imem_req=1 and imem_addr=RESET_PC.
REQ-033 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after release SHALL be ignored because the FSM is in REQ.

Verification
REQ-034 Reset release, imem_gnt=1 every REQ cycle, rvalid 1 cycle after gnt, stall=0 -> if_pc sequence 0x0, 0x4, 0x8, one instruction every 3 cycles.
REQ-035 if_valid=1 at if_pc=0x8, stall=1 for 4 cycles -> if_pc=0x8 and if_instr stay stable; imem_req=0; REQ at 0xC one cycle after stall drops.
REQ-036 In WAIT for 0x10, redirect=1, redirect_pc=0x103 -> DROP, the next rvalid is discarded, and the next request has imem_addr=0x100.
REQ-037 In WAIT, redirect and rvalid in the same cycle, redirect_pc=0x40 -> if_valid stays 0 and the next imem_addr=0x40.
REQ-038 RESET_PC=32'hFFFF_FFFC, first instruction consumed -> next imem_addr=32'h0000_0000.
REQ-039 reset=0 asserted while in WAIT, followed by a stray rvalid after release -> if_valid=0 and imem_addr=RESET_PC.
